result_wr_arbiter: RTL and testbench

- Round-robin arbiter and sequencer for the single write port of the 14-bit-addressed MFCC result memory.
- Three requesters share the port: 0 = energy copy engine, 1 = cepstral (DCT/lifter) writer, 2 = delta writer.
- Each requester issues a locked burst; the arbiter grants one owner at a time, muxes address and data onto a registered write port, enforces a burst-length limit and flags overruns.

---
 rtl/result_wr_arbiter_if.sv | 45 ++++
 rtl/result_wr_arbiter.sv | 157 +++++++++++++++
 tb/tb_result_wr_arbiter.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/result_wr_arbiter_if.sv
// Write-port bundle shared by the three MFCC result writers and the arbiter.
// The slave modport is the arbiter's view; the master modport is the requester/memory side.
interface result_wr_arbiter_if #(
  parameter int ADDR_WIDTH_14 = 14,
  parameter int DATA_WIDTH    = 16
);
  logic                     en_req;
  logic [ADDR_WIDTH_14-1:0] en_addr;
  logic [DATA_WIDTH-1:0]    en_data;
  logic                     en_last;
  logic                     cep_req;
  logic [ADDR_WIDTH_14-1:0] cep_addr;
  logic [DATA_WIDTH-1:0]    cep_data;
  logic                     cep_last;
  logic                     dl_req;
  logic [ADDR_WIDTH_14-1:0] dl_addr;
  logic [DATA_WIDTH-1:0]    dl_data;
  logic                     dl_last;
  logic                     en_gnt;
  logic                     cep_gnt;
  logic                     dl_gnt;
  logic                     result_mem_we;
  logic [ADDR_WIDTH_14-1:0] result_mem_addr;
  logic [DATA_WIDTH-1:0]    result_mem_data;
  logic                     busy;
  logic                     burst_err;

  modport slave (
    input  en_req, en_addr, en_data, en_last,
    input  cep_req, cep_addr, cep_data, cep_last,
    input  dl_req, dl_addr, dl_data, dl_last,
    output en_gnt, cep_gnt, dl_gnt,
    output result_mem_we, result_mem_addr, result_mem_data,
    output busy, burst_err
  );

  modport master (
    output en_req, en_addr, en_data, en_last,
    output cep_req, cep_addr, cep_data, cep_last,
    output dl_req, dl_addr, dl_data, dl_last,
    input  en_gnt, cep_gnt, dl_gnt,
    input  result_mem_we, result_mem_addr, result_mem_data,
    input  busy, burst_err
  );
endinterface

// File: rtl/result_wr_arbiter.sv
// Round-robin owner of the MFCC result memory write port: energy(0), cepstral(1), delta(2).
// Locked bursts, registered write port, forced release with burst_err after MAX_BURST beats.
//
//   state | meaning
//   IDLE  | no owner; pick next requester at/after rr_ptr
//   GRANT | owner locked; each req cycle is a beat written one cycle later
module result_wr_arbiter #(
  parameter int ADDR_WIDTH_14 = 14,
  parameter int DATA_WIDTH    = 16,
  parameter int MAX_BURST     = 128,
  parameter int BCNT_W        = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  result_wr_arbiter_if.slave  bus
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t                   r_state, w_state_nxt;
  logic [1:0]               r_owner, w_owner_nxt;
  logic [1:0]               r_rr_ptr, w_rr_ptr_nxt;
  logic [BCNT_W-1:0]        r_bcnt, w_bcnt_nxt;
  logic [2:0]               r_gnt, w_gnt_nxt;
  logic                     r_we, w_we_nxt;
  logic [ADDR_WIDTH_14-1:0] r_addr, w_addr_nxt;
  logic [DATA_WIDTH-1:0]    r_data, w_data_nxt;
  logic                     r_err, w_err_nxt;

  logic [2:0]               w_req;
  logic [1:0]               w_pick;
  logic                     w_own_req;
  logic                     w_own_last;
  logic [ADDR_WIDTH_14-1:0] w_own_addr;
  logic [DATA_WIDTH-1:0]    w_own_data;
  logic                     w_burst_full;

  assign w_req        = {bus.dl_req, bus.cep_req, bus.en_req};
  assign w_burst_full = (r_bcnt == BCNT_W'(MAX_BURST - 1));

  always_comb begin
    w_pick = 2'd0;
    case (r_rr_ptr)
      2'd1: begin
        if (w_req[1])      w_pick = 2'd1;
        else if (w_req[2]) w_pick = 2'd2;
        else               w_pick = 2'd0;
      end
      2'd2: begin
        if (w_req[2])      w_pick = 2'd2;
        else if (w_req[0]) w_pick = 2'd0;
        else               w_pick = 2'd1;
      end
      default: begin
        if (w_req[0])      w_pick = 2'd0;
        else if (w_req[1]) w_pick = 2'd1;
        else               w_pick = 2'd2;
      end
    endcase
  end

  always_comb begin
    w_own_req  = bus.dl_req;
    w_own_last = bus.dl_last;
    w_own_addr = bus.dl_addr;
    w_own_data = bus.dl_data;
    case (r_owner)
      2'd0: begin
        w_own_req  = bus.en_req;
        w_own_last = bus.en_last;
        w_own_addr = bus.en_addr;
        w_own_data = bus.en_data;
      end
      2'd1: begin
        w_own_req  = bus.cep_req;
        w_own_last = bus.cep_last;
        w_own_addr = bus.cep_addr;
        w_own_data = bus.cep_data;
      end
      default: ;
    endcase
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_owner_nxt  = r_owner;
    w_rr_ptr_nxt = r_rr_ptr;
    w_bcnt_nxt   = r_bcnt;
    w_gnt_nxt    = r_gnt;
    w_we_nxt     = 1'b0;
    w_addr_nxt   = r_addr;
    w_data_nxt   = r_data;
    w_err_nxt    = 1'b0;
    case (r_state)
      IDLE: begin
        if (|w_req) begin
          w_state_nxt = GRANT;
          w_owner_nxt = w_pick;
          w_gnt_nxt   = 3'b001 << w_pick;
          w_bcnt_nxt  = '0;
        end
      end
      GRANT: begin
        if (w_own_req) begin
          w_we_nxt   = 1'b1;
          w_addr_nxt = w_own_addr;
          w_data_nxt = w_own_data;
          // Release on last, or forced on the final allowed beat.
          if (w_own_last || w_burst_full) begin
            w_state_nxt  = IDLE;
            w_gnt_nxt    = 3'b000;
            w_bcnt_nxt   = '0;
            w_rr_ptr_nxt = (r_owner == 2'd2) ? 2'd0 : r_owner + 2'd1;
            w_err_nxt    = ~w_own_last;
          end else begin
            w_bcnt_nxt = r_bcnt + 1'b1;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_owner  <= 2'd0;
      r_rr_ptr <= 2'd0;
      r_bcnt   <= '0;
      r_gnt    <= 3'b000;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_data   <= '0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_owner  <= w_owner_nxt;
      r_rr_ptr <= w_rr_ptr_nxt;
      r_bcnt   <= w_bcnt_nxt;
      r_gnt    <= w_gnt_nxt;
      r_we     <= w_we_nxt;
      r_addr   <= w_addr_nxt;
      r_data   <= w_data_nxt;
      r_err    <= w_err_nxt;
    end
  end

  assign bus.en_gnt          = r_gnt[0];
  assign bus.cep_gnt         = r_gnt[1];
  assign bus.dl_gnt          = r_gnt[2];
  assign bus.result_mem_we   = r_we;
  assign bus.result_mem_addr = r_addr;
  assign bus.result_mem_data = r_data;
  assign bus.busy            = (r_state == GRANT);
  assign bus.burst_err       = r_err;

endmodule

// File: tb/tb_result_wr_arbiter.sv
// Directed vector bench for result_wr_arbiter built with MAX_BURST=4.
// Requester r drives addr = a | (r<<12) and data = {r, a}, so each write identifies its source.
module tb_result_wr_arbiter;

  logic clk;
  logic rst_n;

  result_wr_arbiter_if #(.ADDR_WIDTH_14(14), .DATA_WIDTH(16)) bus ();

  result_wr_arbiter #(
    .ADDR_WIDTH_14(14),
    .DATA_WIDTH   (16),
    .MAX_BURST    (4),
    .BCNT_W       (8)
  ) u_dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  req;
    logic [2:0]  last;
    logic [13:0] a;
    logic [2:0]  gnt;
    logic        we;
    logic [13:0] waddr;
    logic [15:0] wdata;
    logic        busy;
    logic        err;
  } vec_t;

  vec_t vecs[32];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [2:0] gnt, input logic we,
                            input logic [13:0] waddr, input logic [15:0] wdata,
                            input logic busy, input logic err);
    check({tag, " gnt"},  {29'd0, bus.dl_gnt, bus.cep_gnt, bus.en_gnt}, {29'd0, gnt});
    check({tag, " we"},   {31'd0, bus.result_mem_we}, {31'd0, we});
    check({tag, " addr"}, {18'd0, bus.result_mem_addr}, {18'd0, waddr});
    check({tag, " data"}, {16'd0, bus.result_mem_data}, {16'd0, wdata});
    check({tag, " busy"}, {31'd0, bus.busy}, {31'd0, busy});
    check({tag, " err"},  {31'd0, bus.burst_err}, {31'd0, err});
  endtask

  task automatic drive(input logic [2:0] req, input logic [2:0] last, input logic [13:0] a);
    bus.en_req   = req[0];
    bus.cep_req  = req[1];
    bus.dl_req   = req[2];
    bus.en_last  = last[0];
    bus.cep_last = last[1];
    bus.dl_last  = last[2];
    bus.en_addr  = a;
    bus.cep_addr = a | 14'h1000;
    bus.dl_addr  = a | 14'h2000;
    bus.en_data  = {2'b00, a};
    bus.cep_data = {2'b01, a};
    bus.dl_data  = {2'b10, a};
  endtask

  task automatic run_vecs(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      @(negedge clk);
      drive(vecs[i].req, vecs[i].last, vecs[i].a);
      @(posedge clk);
      #1;
      check_outs($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].we, vecs[i].waddr,
                 vecs[i].wdata, vecs[i].busy, vecs[i].err);
    end
  endtask

  initial begin
    //          req     last    a         gnt     we    waddr     wdata      busy  err
    // energy burst of 4, last on beat 4 (= MAX_BURST): normal release
    vecs[0]  = '{3'b001, 3'b000, 14'h000, 3'b001, 1'b0, 14'h0000, 16'h0000, 1'b1, 1'b0};
    vecs[1]  = '{3'b001, 3'b000, 14'h000, 3'b001, 1'b1, 14'h0000, 16'h0000, 1'b1, 1'b0};
    vecs[2]  = '{3'b001, 3'b000, 14'h080, 3'b001, 1'b1, 14'h0080, 16'h0080, 1'b1, 1'b0};
    vecs[3]  = '{3'b001, 3'b000, 14'h100, 3'b001, 1'b1, 14'h0100, 16'h0100, 1'b1, 1'b0};
    vecs[4]  = '{3'b001, 3'b001, 14'h180, 3'b000, 1'b1, 14'h0180, 16'h0180, 1'b0, 1'b0};
    vecs[5]  = '{3'b000, 3'b000, 14'h000, 3'b000, 1'b0, 14'h0180, 16'h0180, 1'b0, 1'b0};
    // rr_ptr=1: cep wins over pending dl; 3-cycle stall with last high while req low
    vecs[6]  = '{3'b110, 3'b000, 14'h010, 3'b010, 1'b0, 14'h0180, 16'h0180, 1'b1, 1'b0};
    vecs[7]  = '{3'b110, 3'b000, 14'h010, 3'b010, 1'b1, 14'h1010, 16'h4010, 1'b1, 1'b0};
    vecs[8]  = '{3'b100, 3'b010, 14'h020, 3'b010, 1'b0, 14'h1010, 16'h4010, 1'b1, 1'b0};
    vecs[9]  = '{3'b100, 3'b010, 14'h020, 3'b010, 1'b0, 14'h1010, 16'h4010, 1'b1, 1'b0};
    vecs[10] = '{3'b100, 3'b010, 14'h020, 3'b010, 1'b0, 14'h1010, 16'h4010, 1'b1, 1'b0};
    vecs[11] = '{3'b110, 3'b010, 14'h020, 3'b000, 1'b1, 14'h1020, 16'h4020, 1'b0, 1'b0};
    vecs[12] = '{3'b100, 3'b000, 14'h030, 3'b100, 1'b0, 14'h1020, 16'h4020, 1'b1, 1'b0};
    vecs[13] = '{3'b100, 3'b000, 14'h030, 3'b100, 1'b1, 14'h2030, 16'h8030, 1'b1, 1'b0};
    // after mid-burst reset: all three held, order en, cep, dl, en
    vecs[14] = '{3'b111, 3'b000, 14'h050, 3'b001, 1'b0, 14'h0000, 16'h0000, 1'b1, 1'b0};
    vecs[15] = '{3'b111, 3'b000, 14'h050, 3'b001, 1'b1, 14'h0050, 16'h0050, 1'b1, 1'b0};
    vecs[16] = '{3'b111, 3'b001, 14'h060, 3'b000, 1'b1, 14'h0060, 16'h0060, 1'b0, 1'b0};
    vecs[17] = '{3'b111, 3'b000, 14'h070, 3'b010, 1'b0, 14'h0060, 16'h0060, 1'b1, 1'b0};
    vecs[18] = '{3'b111, 3'b000, 14'h070, 3'b010, 1'b1, 14'h1070, 16'h4070, 1'b1, 1'b0};
    vecs[19] = '{3'b111, 3'b010, 14'h080, 3'b000, 1'b1, 14'h1080, 16'h4080, 1'b0, 1'b0};
    vecs[20] = '{3'b111, 3'b000, 14'h090, 3'b100, 1'b0, 14'h1080, 16'h4080, 1'b1, 1'b0};
    vecs[21] = '{3'b111, 3'b000, 14'h090, 3'b100, 1'b1, 14'h2090, 16'h8090, 1'b1, 1'b0};
    vecs[22] = '{3'b111, 3'b100, 14'h0A0, 3'b000, 1'b1, 14'h20A0, 16'h80A0, 1'b0, 1'b0};
    vecs[23] = '{3'b111, 3'b000, 14'h0B0, 3'b001, 1'b0, 14'h20A0, 16'h80A0, 1'b1, 1'b0};
    // energy never asserts last: forced release after beat 4, error pulse, cep next
    vecs[24] = '{3'b011, 3'b000, 14'h0B0, 3'b001, 1'b1, 14'h00B0, 16'h00B0, 1'b1, 1'b0};
    vecs[25] = '{3'b011, 3'b000, 14'h0C0, 3'b001, 1'b1, 14'h00C0, 16'h00C0, 1'b1, 1'b0};
    vecs[26] = '{3'b011, 3'b000, 14'h0D0, 3'b001, 1'b1, 14'h00D0, 16'h00D0, 1'b1, 1'b0};
    vecs[27] = '{3'b011, 3'b000, 14'h0E0, 3'b000, 1'b1, 14'h00E0, 16'h00E0, 1'b0, 1'b1};
    vecs[28] = '{3'b011, 3'b000, 14'h0F0, 3'b010, 1'b0, 14'h00E0, 16'h00E0, 1'b1, 1'b0};
    vecs[29] = '{3'b011, 3'b010, 14'h100, 3'b000, 1'b1, 14'h1100, 16'h4100, 1'b0, 1'b0};
    vecs[30] = '{3'b001, 3'b000, 14'h110, 3'b001, 1'b0, 14'h1100, 16'h4100, 1'b1, 1'b0};
    vecs[31] = '{3'b001, 3'b001, 14'h110, 3'b000, 1'b1, 14'h0110, 16'h0110, 1'b0, 1'b0};

    rst_n = 1'b0;
    drive(3'b000, 3'b000, 14'h000);
    repeat (2) @(posedge clk);
    #1;
    check_outs("reset", 3'b000, 1'b0, 14'h0000, 16'h0000, 1'b0, 1'b0);
    rst_n = 1'b1;

    run_vecs(0, 13);

    // reset asserted during delta beat 2: outputs clear at once, no write follows
    @(negedge clk);
    drive(3'b100, 3'b000, 14'h040);
    #2 rst_n = 1'b0;
    #1;
    check_outs("midrst_async", 3'b000, 1'b0, 14'h0000, 16'h0000, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check_outs("midrst_edge", 3'b000, 1'b0, 14'h0000, 16'h0000, 1'b0, 1'b0);
    rst_n = 1'b1;

    run_vecs(14, 31);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
